// File: rtl/cnn_layer_accel_job_issuer.sv
// Host-side job issuer for cnn_layer_accel_quad: queues parameter words and runs the
// start/fetch/complete handshake. Optional watchdog enabled by CNL_JOB_TIMEOUT_EN.
module cnn_layer_accel_job_issuer #(
  parameter int C_JOB_FIFO_DEPTH = 4,
  parameter int C_PARAM_WIDTH    = 128,
  parameter int C_CNT_WIDTH      = 16,
  parameter int C_TIMEOUT_CYCLES = 65535
) (
  input  logic                              clk_if,
  input  logic                              rst,
  input  logic                              job_in_valid,
  output logic                              job_in_ready,
  input  logic [C_PARAM_WIDTH-1:0]          job_in_params,
  output logic                              job_start,
  input  logic                              job_accept,
  output logic [C_PARAM_WIDTH-1:0]          job_parameters,
  input  logic                              job_fetch_request,
  output logic                              job_fetch_ack,
  output logic                              job_fetch_complete,
  input  logic                              job_complete,
  output logic                              job_complete_ack,
  output logic                              fetch_start,
  input  logic                              fetch_done,
  output logic                              busy,
  output logic [$clog2(C_JOB_FIFO_DEPTH):0] fifo_count,
  output logic [C_CNT_WIDTH-1:0]            jobs_done,
  output logic                              timeout_err
);

  localparam int PTR_W = $clog2(C_JOB_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT_FREQ, S_FETCH, S_WAIT_DONE} state_t;

  logic [C_PARAM_WIDTH-1:0] mem_q [C_JOB_FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  state_t                   state_q, state_d;
  logic                     start_q, start_d;
  logic [C_PARAM_WIDTH-1:0] params_q, params_d, head, head_nxt;
  logic                     fack_q, fack_d, fst_q, fst_d, fcmp_q, fcmp_d, cack_q, cack_d;
  logic                     busy_q, busy_d;
  logic [C_CNT_WIDTH-1:0]   jobs_done_q, jobs_done_d;
  logic                     push, pop;

  assign job_in_ready = (count_q != CNT_W'(C_JOB_FIFO_DEPTH));
  assign push         = job_in_valid && job_in_ready;
  assign pop          = (state_q == S_START) && job_accept;
  assign head         = mem_q[rd_ptr_q];
  // A job pushed into an empty queue in the same cycle WAIT_DONE finishes is not yet in mem_q.
  assign head_nxt     = (count_q == '0) ? job_in_params : head;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

`ifdef CNL_JOB_TIMEOUT_EN
  localparam int TMO_W = $clog2(C_TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_err_q, tmo_err_d;
  assign timeout_err = tmo_err_q;
`else
  logic unused_tmo;
  assign unused_tmo  = (C_TIMEOUT_CYCLES != 0);
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    start_d     = start_q;
    params_d    = params_q;
    fack_d      = 1'b0;
    fst_d       = 1'b0;
    fcmp_d      = 1'b0;
    cack_d      = 1'b0;
    jobs_done_d = jobs_done_q;
    case (state_q)
      S_IDLE: if (count_q != '0) begin
        state_d  = S_START;
        start_d  = 1'b1;
        params_d = head;
      end
      S_START: if (job_accept) begin
        state_d = S_WAIT_FREQ;
        start_d = 1'b0;
      end
      S_WAIT_FREQ: if (job_fetch_request) begin
        state_d = S_FETCH;
        fack_d  = 1'b1;
        fst_d   = 1'b1;
      end
      S_FETCH: if (fetch_done) begin
        state_d = S_WAIT_DONE;
        fcmp_d  = 1'b1;
      end
      S_WAIT_DONE: if (job_complete) begin
        cack_d      = 1'b1;
        jobs_done_d = jobs_done_q + 1'b1;
        if (count_d != '0) begin
          state_d  = S_START;
          start_d  = 1'b1;
          params_d = head_nxt;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef CNL_JOB_TIMEOUT_EN
    tmo_err_d = tmo_err_q;
    tmo_cnt_d = '0;
    if ((state_q == S_WAIT_FREQ || state_q == S_FETCH || state_q == S_WAIT_DONE) &&
        state_d == state_q) begin
      // Counter hitting the limit drops the job without acknowledging it.
      if (tmo_cnt_q == TMO_W'(C_TIMEOUT_CYCLES - 1)) begin
        tmo_err_d = 1'b1;
        state_d   = S_IDLE;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
    end
`endif
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_if) begin
    if (push) mem_q[wr_ptr_q] <= job_in_params;
  end

  always_ff @(posedge clk_if or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= S_IDLE;
      start_q     <= 1'b0;
      params_q    <= '0;
      fack_q      <= 1'b0;
      fst_q       <= 1'b0;
      fcmp_q      <= 1'b0;
      cack_q      <= 1'b0;
      busy_q      <= 1'b0;
      jobs_done_q <= '0;
`ifdef CNL_JOB_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      tmo_err_q   <= 1'b0;
`endif
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      start_q     <= start_d;
      params_q    <= params_d;
      fack_q      <= fack_d;
      fst_q       <= fst_d;
      fcmp_q      <= fcmp_d;
      cack_q      <= cack_d;
      busy_q      <= busy_d;
      jobs_done_q <= jobs_done_d;
`ifdef CNL_JOB_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
      tmo_err_q   <= tmo_err_d;
`endif
    end
  end

  assign job_start          = start_q;
  assign job_parameters     = params_q;
  assign job_fetch_ack      = fack_q;
  assign fetch_start        = fst_q;
  assign job_fetch_complete = fcmp_q;
  assign job_complete_ack   = cack_q;
  assign busy               = busy_q;
  assign fifo_count         = count_q;
  assign jobs_done          = jobs_done_q;

endmodule
